// File: rtl/debug_display_unit.sv
// debug_display_unit: run/step control, memory/register viewer address and
// an 8-digit multiplexed 7-segment display for the pipelined CPU.
// Optional feature macro: DDU_PC_VIEW_EN (when defined, continuous run shows
// Show_PC on the display instead of the memory/register view).
module debug_display_unit #(
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cont,
    input  logic        step,
    input  logic        inc,
    input  logic        dec,
    input  logic        mem,
    input  logic [31:0] Show_PC,
    input  logic [31:0] Show_DM_Data,
    input  logic [31:0] Show_RF_Data,
    output logic        cpu_run,
    output logic [31:0] Show_DM_Addr,
    output logic [4:0]  Show_RF_Addr,
    output logic [7:0]  addr_led,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    // Button index order: 0 = step, 1 = inc, 2 = dec.
    localparam int NBTN = 3;

    logic [NBTN-1:0]   w_btn;
    logic [NBTN-1:0]   r_sync1;
    logic [NBTN-1:0]   r_sync2;
    logic [NBTN-1:0]   r_hist;
    logic [NBTN-1:0]   w_pulse;
    logic              r_cpu_run;
    logic [7:0]        r_view_addr;
    logic [SCAN_W-1:0] r_scan;
    logic [2:0]        w_digit;
    logic [31:0]       w_value;
    logic [3:0]        w_nibble;
    logic [7:0]        w_glyph;
    logic [7:0]        r_an;
    logic [7:0]        r_seg;

    assign w_btn = {dec, inc, step};

    // Two-flop synchronizer plus history flop for every raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Rising-edge detect: one-cycle pulse per press, regardless of hold time.
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_pulse
            assign w_pulse[gi] = r_sync2[gi] & ~r_hist[gi];
        end
    endgenerate

    // CPU clock enable: continuous level, or exactly one cycle per step press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_run <= 1'b0;
        end else begin
            r_cpu_run <= cont | w_pulse[0];
        end
    end

    // Viewer address: wraps modulo 256; coincident inc/dec cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_view_addr <= 8'h00;
        end else begin
            case ({w_pulse[2], w_pulse[1]})
                2'b01:   r_view_addr <= r_view_addr + 8'd1;
                2'b10:   r_view_addr <= r_view_addr - 8'd1;
                default: r_view_addr <= r_view_addr;
            endcase
        end
    end

    assign cpu_run      = r_cpu_run;
    assign addr_led     = r_view_addr;
    assign Show_DM_Addr = {22'b0, r_view_addr, 2'b00};
    assign Show_RF_Addr = r_view_addr[4:0];

    // Free-running scan counter; its top three bits select the active digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign w_digit = r_scan[SCAN_W-1 -: 3];

`ifdef DDU_PC_VIEW_EN
    // While running continuously, the PC is the most useful thing to watch.
    assign w_value = cont ? Show_PC : (mem ? Show_DM_Data : Show_RF_Data);
`else
    // Show_PC is deliberately not used in this build.
    logic w_unused_pc;
    assign w_unused_pc = ^Show_PC;
    assign w_value     = mem ? Show_DM_Data : Show_RF_Data;
`endif

    assign w_nibble = w_value[{w_digit, 2'b00} +: 4];

    // Hex glyphs, active-low {dp,g,f,e,d,c,b,a}; dp always off.
    always_comb begin
        w_glyph = 8'hFF;
        case (w_nibble)
            4'h0: w_glyph = 8'hC0;
            4'h1: w_glyph = 8'hF9;
            4'h2: w_glyph = 8'hA4;
            4'h3: w_glyph = 8'hB0;
            4'h4: w_glyph = 8'h99;
            4'h5: w_glyph = 8'h92;
            4'h6: w_glyph = 8'h82;
            4'h7: w_glyph = 8'hF8;
            4'h8: w_glyph = 8'h80;
            4'h9: w_glyph = 8'h90;
            4'hA: w_glyph = 8'h88;
            4'hB: w_glyph = 8'h83;
            4'hC: w_glyph = 8'hC6;
            4'hD: w_glyph = 8'hA1;
            4'hE: w_glyph = 8'h86;
            4'hF: w_glyph = 8'h8E;
            default: w_glyph = 8'hFF;
        endcase
    end

    // Registered anode/segment drive; blank during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'd1 << w_digit);
            r_seg <= w_glyph;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
